// File: rtl/ng_fetch_ctrl.sv
// Instruction-fetch sequencer: drives a req/rvalid instruction memory, pulses
// core_en once per fetched word, with debug halt/step, fetch timeout trap and a retired counter.
module ng_fetch_ctrl #(
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       TIMEOUT   = 255,
    parameter int unsigned       CNT_W     = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    output logic              core_en,
    output logic [DATA_W-1:0] instr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    input  logic              dbg_halt,
    input  logic              dbg_step,
    output logic              halted,
    output logic              trap,
    output logic [CNT_W-1:0]  retired
);

    localparam int unsigned     TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALT,
        S_TRAP
    } state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_cnt;
    logic            step_pend;
    logic            to_hit;
    logic            fetch_go;

    assign to_hit   = (TIMEOUT != 0) && (to_cnt == TO_LAST);
    assign fetch_go = (state_q == S_FETCH) && !(dbg_halt && !step_pend);
    assign core_en  = (state_q == S_EXEC);
    assign halted   = (state_q == S_HALT) || (state_q == S_TRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = fetch_go ? S_WAIT : S_HALT;
            S_WAIT: begin
                // returned data wins over a timeout landing on the same cycle
                if (mem_rvalid)  state_d = S_WAIT == state_q ? S_EXEC : S_WAIT;
                else if (to_hit) state_d = S_TRAP;
            end
            S_EXEC:  state_d = step_pend ? S_HALT : S_FETCH;
            S_HALT:  if (dbg_step || !dbg_halt) state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            instr     <= NOP_INSTR;
            trap      <= 1'b0;
            retired   <= '0;
            to_cnt    <= '0;
            step_pend <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (fetch_go) begin
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                        to_cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        instr   <= mem_rdata;
                        mem_req <= 1'b0;
                    end else if (to_hit) begin
                        mem_req <= 1'b0;
                        trap    <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_EXEC: begin
                    retired   <= retired + CNT_W'(1);
                    step_pend <= 1'b0;
                end
                S_HALT: begin
                    if (dbg_step) step_pend <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ng_fetch_ctrl.sv
// Randomized self-checking bench for ng_fetch_ctrl: a transaction-level memory/core
// model predicts fetched words, latencies, retire counts and debug/trap behaviour.
module tb_ng_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc;
    logic        core_en;
    logic [15:0] instr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        dbg_halt;
    logic        dbg_step;
    logic        halted;
    logic        trap;
    logic [3:0]  retired;

    ng_fetch_ctrl #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .TIMEOUT  (8),
        .CNT_W    (4),
        .NOP_INSTR(16'h0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc        (pc),
        .core_en   (core_en),
        .instr     (instr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid),
        .dbg_halt  (dbg_halt),
        .dbg_step  (dbg_step),
        .halted    (halted),
        .trap      (trap),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cycle = 0;
    int          en_count = 0;
    int          exp_ret = 0;
    int          req_cycle = 0;
    int          lat = 0;
    int          left = 0;
    int          fixed_lat = 0;
    int          cur_run = 0;
    int          req_len = 0;
    int          hm_bad = 0;
    bit          busy = 1'b0;
    bit          silent = 1'b0;
    bit          jump = 1'b0;
    logic [15:0] req_addr = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic logic [15:0] word(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    // One clock of the surrounding system, evaluated at the falling edge:
    // score the core side, then act as memory for the coming rising edge.
    task automatic cyc_step();
        @(negedge clk);
        cycle++;
        if (mem_req) cur_run++;
        else if (cur_run != 0) begin
            req_len = cur_run;
            cur_run = 0;
        end
        if (halted && (mem_req || core_en)) hm_bad++;
        if (core_en) begin
            check("instr", 32'(instr), 32'(word(req_addr)));
            check("exec_lat", 32'(cycle - req_cycle), 32'(lat + 1));
            check("req_len", 32'(req_len), 32'(lat + 1));
            check("retired", 32'(retired), 32'(exp_ret % 16));
            exp_ret++;
            en_count++;
            if (jump && ($urandom_range(0, 3) == 0)) pc = 16'($urandom);
            else                                     pc = pc + 16'd1;
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 16'($urandom);
        if (busy && !mem_req) begin
            if (!silent) check("req_held", 32'(mem_req), 32'd1);
            busy = 1'b0;
        end else if (!busy && mem_req) begin
            busy      = 1'b1;
            req_addr  = mem_addr;
            req_cycle = cycle;
            lat       = (fixed_lat < 0) ? int'($urandom_range(0, 7)) : fixed_lat;
            left      = lat;
            check("req_addr", 32'(mem_addr), 32'(pc));
        end else if (busy) begin
            check("addr_stable", 32'(mem_addr), 32'(req_addr));
        end
        if (busy && !silent) begin
            if (left == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = word(req_addr);
                busy       = 1'b0;
            end else begin
                left--;
            end
        end
    endtask

    task automatic run_en(input int n, input int budget);
        int start;
        int k;
        start = en_count;
        k = 0;
        while ((en_count - start) < n && k < budget) begin
            cyc_step();
            k++;
        end
        check("run_budget", 32'(en_count - start), 32'(n));
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        mem_rvalid = 1'b0;
        dbg_halt   = 1'b0;
        dbg_step   = 1'b0;
        repeat (2) @(negedge clk);
        busy    = 1'b0;
        cur_run = 0;
        exp_ret = 0;
        pc      = '0;
        rst_n   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        int e0, k, n, reqs;
        rst_n = 1'b0; pc = '0; mem_rdata = '0; mem_rvalid = 1'b0;
        dbg_halt = 1'b0; dbg_step = 1'b0;
        #1;
        check("rst_core_en", 32'(core_en), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_instr", 32'(instr), 32'h0000);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);

        // zero-wait memory, sequential pc
        do_reset();
        fixed_lat = 0;
        run_en(10, 100);
        cyc_step();
        check("retired_10", 32'(retired), 32'd10);

        // four-cycle memory latency
        fixed_lat = 4;
        run_en(4, 100);

        // halt raised mid-fetch of address 5, with a stray step outside HALT
        do_reset();
        fixed_lat = 2;
        k = 0;
        while (!(busy && req_addr == 16'd5) && k < 100) begin
            cyc_step();
            k++;
        end
        check("reach_addr5", 32'(req_addr), 32'd5);
        dbg_halt = 1'b1;
        dbg_step = 1'b1;
        e0 = en_count;
        cyc_step();
        dbg_step = 1'b0;
        repeat (20) cyc_step();
        check("halt_one_exec", 32'(en_count - e0), 32'd1);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_no_req", 32'(mem_req), 32'd0);
        check("halt_pc", 32'(pc), 32'd6);
        for (int s = 0; s < 2; s++) begin
            e0 = en_count;
            dbg_step = 1'b1;
            cyc_step();
            dbg_step = 1'b0;
            repeat (15) cyc_step();
            check("step_one_exec", 32'(en_count - e0), 32'd1);
            check("step_halted", 32'(halted), 32'd1);
        end
        // step and halt release together: one instruction, a HALT, then free run
        dbg_step = 1'b1;
        dbg_halt = 1'b0;
        cyc_step();
        dbg_step = 1'b0;
        run_en(1, 20);
        cyc_step();
        check("step_then_halt", 32'(halted), 32'd1);
        run_en(3, 40);
        check("resume_halted", 32'(halted), 32'd0);

        // randomized latency and pc jumps, wrapping the 4-bit counter
        fixed_lat = -1;
        jump = 1'b1;
        run_en(60, 1000);
        jump = 1'b0;

        // fetch timeout
        do_reset();
        silent = 1'b1;
        k = 0;
        while (!busy && k < 10) begin
            cyc_step();
            k++;
        end
        n = 1;
        k = 0;
        while (k < 20) begin
            cyc_step();
            k++;
            if (mem_req) n++;
            else break;
        end
        check("trap_req_len", 32'(n), 32'd8);
        check("trap_flag", 32'(trap), 32'd1);
        check("trap_halted", 32'(halted), 32'd1);
        check("trap_no_req", 32'(mem_req), 32'd0);
        e0 = en_count;
        reqs = 0;
        repeat (12) begin
            dbg_halt = 1'($urandom);
            dbg_step = 1'($urandom);
            cyc_step();
            if (mem_req) reqs++;
        end
        check("trap_dbg_req", 32'(reqs), 32'd0);
        check("trap_dbg_exec", 32'(en_count - e0), 32'd0);
        check("trap_sticky", 32'(trap), 32'd1);
        rst_n = 1'b0;
        #1;
        check("trap_rst_clear", 32'(trap), 32'd0);
        check("trap_rst_halted", 32'(halted), 32'd0);
        do_reset();
        silent = 1'b0;
        fixed_lat = 1;
        cyc_step();
        check("trap_restart_req", 32'(mem_req), 32'd1);
        run_en(2, 30);

        // reset in the middle of WAIT, stray rvalid right after release
        fixed_lat = 5;
        k = 0;
        while (!busy && k < 20) begin
            cyc_step();
            k++;
        end
        cyc_step();
        #2 rst_n = 1'b0;
        #1;
        check("async_req_drop", 32'(mem_req), 32'd0);
        busy = 1'b0; cur_run = 0; exp_ret = 0; pc = '0;
        repeat (2) cyc_step();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hDEAD;
        e0 = en_count;
        cyc_step();
        check("stray_no_exec", 32'(en_count - e0), 32'd0);
        check("stray_instr_nop", 32'(instr), 32'h0000);
        check("stray_new_req", 32'(mem_req), 32'd1);
        run_en(2, 40);

        // retired counter wrap
        do_reset();
        fixed_lat = 0;
        run_en(17, 100);
        cyc_step();
        check("retired_wrap", 32'(retired), 32'd1);

        check("halted_exclusive", 32'(hm_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
